// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: op encodings, FSM states, payload.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined op codes produce 0 (and therefore Zero).
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]   alu_result,
  output logic              zero
);

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_control))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = XLEN'($signed(src_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; one registered op in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][XLEN-1:0]     req_a,
  input  logic [N_REQ-1:0][XLEN-1:0]     req_b,
  input  logic [N_REQ-1:0][CTRL_W-1:0]   req_ctrl,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [XLEN-1:0]                rsp_result,
  output logic                           rsp_zero,
  output logic                           busy
);

  arb_state_e       state_q, state_n;
  logic             last_grant_q;
  logic             owner_q;
  alu_req_t         op_q;
  logic [XLEN-1:0]  res_q;
  logic             zero_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             busy_q;

  logic             grant;
  logic             accept;
  logic [XLEN-1:0]  alu_res;
  logic             alu_zero;

  alu u_alu (
    .src_a       (op_q.a),
    .src_b       (op_q.b),
    .alu_control (op_q.ctrl),
    .alu_result  (alu_res),
    .zero        (alu_zero)
  );

  // Next state, grant selection and the combinational ready.
  always_comb begin
    state_n   = state_q;
    grant     = 1'b0;
    accept    = 1'b0;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          // A tie goes to whoever did not win last; otherwise the lone requester.
          grant            = (&req_valid) ? ~last_grant_q : req_valid[1];
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_n          = ST_EXEC;
        end
      end
      ST_EXEC: state_n = ST_RESP;
      ST_RESP: if (rsp_ready[owner_q]) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n != ST_IDLE);
      if (accept) begin
        op_q         <= '{ctrl: req_ctrl[grant], a: req_a[grant], b: req_b[grant]};
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
      end
      rsp_valid_q <= (state_n == ST_RESP) ? (N_REQ'(1) << owner_q) : '0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then a randomized transaction-level scoreboard.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_ctrl;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.N_REQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation from requester i, starting and ending in IDLE.
  task automatic do_op(input int i, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [1:0]  oh;
    logic [31:0] exp;
    oh  = 2'(1) << i;
    exp = ref_alu(c, a, b);
    req_valid = oh; req_a[i] = a; req_b[i] = b; req_ctrl[i] = c;
    @(negedge clk); chk({tag, "_rdy"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 2'b00; req_a[i] = $urandom; req_b[i] = $urandom;
    @(negedge clk); chk({tag, "_exec_rv"}, 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_rv"},   32'(rsp_valid), 32'(oh));
    chk({tag, "_res"},  rsp_result, exp);
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp == 32'd0));
    tick();
  endtask

  logic        outst, own, lastg, g;
  int          cyc;
  logic [31:0] eres, bp_exp;
  logic [1:0]  eg;
  int          t;
  logic        fexp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    req_a = '0; req_b = '0; req_ctrl = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv",   32'(rsp_valid), 32'd0);
    chk("rst_res",  rsp_result, 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rdy",  32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(0, 3'b000, 32'd5, 32'd7, "add57");

    // Reset while an op sits in EXEC: everything drops, nothing comes back.
    req_valid = 2'b01; req_ctrl[0] = 3'b000; req_a[0] = 32'd1; req_b[0] = 32'd2;
    tick();
    req_valid = 2'b00;
    @(negedge clk); chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rv",   32'(rsp_valid), 32'd0);
    chk("mid_res",  rsp_result, 32'd0);
    chk("mid_zero", 32'(rsp_zero), 32'd0);
    chk("mid_rdy",  32'(req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("post_rst_rv", 32'(rsp_valid), 32'd0);
    end
    tick();

    // Simultaneous requests: first tie after reset goes to requester 0.
    req_valid = 2'b11;
    req_ctrl[0] = 3'b001; req_a[0] = 32'd3;          req_b[0] = 32'd3;
    req_ctrl[1] = 3'b101; req_a[1] = 32'hFFFF_FFFF;  req_b[1] = 32'd1;
    @(negedge clk); chk("sim_rdy0", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b10;
    @(negedge clk); chk("sim_exec_rdy", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("sim_rv0",   32'(rsp_valid), 32'h1);
    chk("sim_res0",  rsp_result, 32'd0);
    chk("sim_zero0", 32'(rsp_zero), 32'd1);
    tick();
    @(negedge clk); chk("sim_rdy1", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("sim_rv1",   32'(rsp_valid), 32'h2);
    chk("sim_res1",  rsp_result, 32'd1);
    chk("sim_zero1", 32'(rsp_zero), 32'd0);
    tick();

    // Fairness with both requesters held valid.
    req_valid = 2'b11; fexp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); t = 0;
      while (req_ready == 2'b00 && t < 8) begin @(negedge clk); t++; end
      chk($sformatf("fair%0d", k), 32'(req_ready), 32'(2'(1) << fexp));
      fexp = ~fexp;
      tick();
    end
    req_valid = 2'b00;
    repeat (3) tick();

    // Backpressure on requester 1's response; requester 0 waits.
    rsp_ready = 2'b01;
    req_valid = 2'b10; req_ctrl[1] = 3'b000; req_a[1] = 32'h1234_5678; req_b[1] = 32'h1111_1111;
    bp_exp = 32'h2345_6789;
    @(negedge clk); chk("bp_rdy1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b01; req_ctrl[0] = 3'b010; req_a[0] = $urandom; req_b[0] = $urandom;
    @(negedge clk); chk("bp_exec_rdy", 32'(req_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rv",  32'(rsp_valid), 32'h2);
      chk("bp_res", rsp_result, bp_exp);
      chk("bp_rdy", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk); chk("bp_rv_last", 32'(rsp_valid), 32'h2);
    tick();
    @(negedge clk); chk("bp_regrant", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    repeat (3) tick();

    do_op(1, 3'b111, 32'd1,          32'd1,          "unk");
    do_op(0, 3'b000, 32'h7FFF_FFFF,  32'd1,          "add_ovf");
    do_op(1, 3'b001, 32'd0,          32'd1,          "sub_wrap");
    do_op(0, 3'b101, 32'h8000_0000,  32'd0,          "slt_neg");
    do_op(1, 3'b010, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  "and");
    do_op(0, 3'b011, 32'hF000_0000,  32'h0000_000F,  "or");

    // Randomized phase from a fresh reset against the transaction-level model.
    rst_n = 1'b0; req_valid = 2'b00;
    tick(); rst_n = 1'b1;
    outst = 1'b0; own = 1'b0; lastg = 1'b1; cyc = 0; eres = '0;
    for (int n = 0; n < 2000; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_a[i] = rnd_word(); req_b[i] = rnd_word(); req_ctrl[i] = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (outst) begin
        cyc++;
        chk("r_rdy_busy", 32'(req_ready), 32'd0);
        chk("r_busy1",    32'(busy), 32'd1);
        if (cyc == 1) begin
          chk("r_exec_rv", 32'(rsp_valid), 32'd0);
        end else begin
          chk("r_rv",   32'(rsp_valid), 32'(2'(1) << own));
          chk("r_res",  rsp_result, eres);
          chk("r_zero", 32'(rsp_zero), 32'(eres == 32'd0));
          if (rsp_ready[own]) outst = 1'b0;
        end
      end else begin
        eg = (req_valid == 2'b11) ? (lastg ? 2'b01 : 2'b10) : req_valid;
        chk("r_grant",   32'(req_ready), 32'(eg));
        chk("r_busy0",   32'(busy), 32'd0);
        chk("r_idle_rv", 32'(rsp_valid), 32'd0);
        if (req_valid != 2'b00) begin
          g     = (req_valid == 2'b11) ? ~lastg : req_valid[1];
          outst = 1'b1; cyc = 0; own = g; lastg = g;
          eres  = ref_alu(req_ctrl[g], req_a[g], req_b[g]);
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
